// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts PC fetches over valid/ready, reads the
// word at the accept edge, delays it LATENCY cycles, and queues it in an in-order FIFO.
module imem_responder #(
    parameter logic [31:0] BASE       = 32'h0000_3000,
    parameter int          ADDR_W     = 10,
    parameter int          LATENCY    = 2,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_inst,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-3:0] ld_widx,
    input  logic [31:0]       ld_data
);

    localparam int             WORDS    = 2 ** (ADDR_W - 2);
    localparam logic [31:0]    SPAN     = 32'(2 ** ADDR_W);
    localparam int             PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int             CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0]  LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [31:0]       mem [WORDS];
    logic [31:0]       off;
    logic              req_err;
    logic [ADDR_W-3:0] widx;
    logic              accept;
    logic              pop;

    logic [31:0]        p_inst [LATENCY];
    logic [LATENCY-1:0] p_err;
    logic [LATENCY-1:0] p_valid;
    logic               f_wr;

    logic [31:0]   f_inst [FIFO_DEPTH];
    logic          f_err  [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] f_cnt;
    logic [CW-1:0] f_cnt_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          ready_q;

    assign off     = req_addr - BASE;
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || (off >= SPAN);
    assign widx    = off[ADDR_W-1:2];
    assign accept  = req_valid && ready_q;
    assign pop     = rsp_valid && rsp_ready;
    assign f_wr    = p_valid[LATENCY-1];

    // NOTE: the program store and the data payloads carry no reset; only the
    // control state (valids, pointers, counters) needs a defined value.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_widx] <= ld_data;
        end
    end

    // Reading mem here samples the pre-edge contents, so a same-edge load
    // to the requested word returns the old word.
    always_ff @(posedge clk) begin
        p_inst[0] <= req_err ? 32'h0 : mem[widx];
        p_err[0]  <= req_err;
        for (int i = 1; i < LATENCY; i++) begin
            p_inst[i] <= p_inst[i-1];
            p_err[i]  <= p_err[i-1];
        end
        if (f_wr) begin
            f_inst[wptr] <= p_inst[LATENCY-1];
            f_err[wptr]  <= p_err[LATENCY-1];
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block can infer a latch.
    always_comb begin
        cnt_next   = cnt;
        f_cnt_next = f_cnt;
        if (accept && !pop) begin
            cnt_next = cnt + CW'(1);
        end else if (!accept && pop) begin
            cnt_next = cnt - CW'(1);
        end
        if (f_wr && !pop) begin
            f_cnt_next = f_cnt + CW'(1);
        end else if (!f_wr && pop) begin
            f_cnt_next = f_cnt - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_valid <= '0;
            wptr    <= '0;
            rptr    <= '0;
            f_cnt   <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            p_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                p_valid[i] <= p_valid[i-1];
            end
            if (f_wr) begin
                wptr <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);
            end
            f_cnt   <= f_cnt_next;
            cnt     <= cnt_next;
            // Ready is registered from the next count so it stays low in reset.
            ready_q <= (cnt_next < DEPTH_C);
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = (f_cnt != '0);
    assign rsp_inst  = rsp_valid ? f_inst[rptr] : 32'h0;
    assign rsp_err   = rsp_valid && f_err[rptr];

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios on a LATENCY=2 instance and
// randomized traffic on LATENCY=1 and LATENCY=4 instances against a scoreboard.
module tb_imem_responder;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          DEPTH = 4;
    localparam int          NI    = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_widx = '0;
    logic [31:0] ld_data = '0;

    logic        req_valid [NI];
    logic        req_ready [NI];
    logic [31:0] req_addr  [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_inst  [NI];
    logic        rsp_err   [NI];

    int lat [NI] = '{2, 1, 4};

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        imem_responder #(.BASE(BASE), .ADDR_W(10), .LATENCY(L), .FIFO_DEPTH(DEPTH)) dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_inst  (rsp_inst[g]),
            .rsp_err   (rsp_err[g]),
            .ld_en     (ld_en),
            .ld_widx   (ld_widx),
            .ld_data   (ld_data)
        );
    end

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          acc_cyc;
    } exp_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] got_inst [$];
    logic        got_err  [$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected response from the address rules alone.
    task automatic ref_rsp(input logic [31:0] addr, output logic [31:0] inst, output logic err);
        err  = (addr % 4 != 0) || (addr < BASE) || (addr >= BASE + 32'd1024);
        inst = err ? 32'h0 : ref_mem[(addr - BASE) / 4];
    endtask

    // Collect up to n responses with rsp_ready held high.
    task automatic drain(input int d, input int n, input int max_cyc);
        got_inst.delete();
        got_err.delete();
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        for (int i = 0; i < max_cyc && got_inst.size() < n; i++) begin
            if (rsp_valid[d]) begin
                got_inst.push_back(rsp_inst[d]);
                got_err.push_back(rsp_err[d]);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = BASE;
            rsp_ready[i] = 1'b0;
        end
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (req_ready[i] !== 1'b0 || rsp_valid[i] !== 1'b0 || rsp_inst[i] !== 32'h0 || rsp_err[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: ready=%b valid=%b inst=%h err=%b, required 0 0 0 0",
                         i, req_ready[i], rsp_valid[i], rsp_inst[i], rsp_err[i]);
            end
        end
        reset = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (req_ready[i] !== 1'b1 || rsp_valid[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_release[%0d]: ready=%b valid=%b, required 1 0", i, req_ready[i], rsp_valid[i]);
            end
        end
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) begin
            ld_en   = 1'b1;
            ld_widx = 8'(i);
            ld_data = (i == 0) ? 32'h2408_0005 : (i == 1) ? 32'h8C09_0000 : (i == 3) ? 32'h0 : $urandom;
            ref_mem[i] = ld_data;
            tick();
        end
        ld_en = 1'b0;
    endtask

    task automatic test_basic();
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0]  = BASE;
        tick();
        req_addr[0]  = BASE + 32'd4;
        tick();
        req_valid[0] = 1'b0;
        n_vec++;
        if (rsp_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_early: valid=%b one edge after first accept, required 0", rsp_valid[0]);
        end
        tick();
        n_vec++;
        if (rsp_valid[0] !== 1'b1 || rsp_inst[0] !== 32'h2408_0005 || rsp_err[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_first: valid=%b inst=%h err=%b, required 1 24080005 0", rsp_valid[0], rsp_inst[0], rsp_err[0]);
        end
        tick();
        n_vec++;
        if (rsp_valid[0] !== 1'b1 || rsp_inst[0] !== 32'h8C09_0000 || rsp_err[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_second: valid=%b inst=%h err=%b, required 1 8c090000 0", rsp_valid[0], rsp_inst[0], rsp_err[0]);
        end
        tick();
        n_vec++;
        if (rsp_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_empty: valid=%b, required 0", rsp_valid[0]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0000_3002;
        addrs[1] = 32'h0000_2FFC;
        addrs[2] = 32'h0000_3400;
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid[0] = 1'b1;
            req_addr[0]  = addrs[i];
            tick();
        end
        drain(0, 3, 20);
        n_vec++;
        if (got_inst.size() != 3) begin
            n_bad++;
            $display("FAIL err_count: got %0d responses, required 3", got_inst.size());
        end
        for (int i = 0; i < got_inst.size(); i++) begin
            n_vec++;
            if (got_inst[i] !== 32'h0 || got_err[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL err_rsp[%0d]: inst=%h err=%b, required 00000000 1", i, got_inst[i], got_err[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          acc = 0;
        logic        have_head = 1'b0;
        logic        moved = 1'b0;
        logic [31:0] head = '0;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_addr[0]  = BASE;
        for (int i = 0; i < 12; i++) begin
            if (req_ready[0]) acc++;
            tick();
            req_addr[0] = BASE + 32'(4 * acc);
            if (rsp_valid[0]) begin
                if (!have_head) begin
                    head      = rsp_inst[0];
                    have_head = 1'b1;
                end else if (rsp_inst[0] !== head) begin
                    moved = 1'b1;
                end
            end
        end
        n_vec++;
        if (acc != DEPTH || req_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_accepts: accepts=%0d ready=%b, required %0d 0", acc, req_ready[0], DEPTH);
        end
        n_vec++;
        if (rsp_valid[0] !== 1'b1 || head !== ref_mem[0] || moved) begin
            n_bad++;
            $display("FAIL bp_head: valid=%b head=%h moved=%b, required 1 %h 0", rsp_valid[0], head, moved, ref_mem[0]);
        end
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        n_vec++;
        if (req_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_ready_rise: ready=%b after one pop, required 1", req_ready[0]);
        end
        acc++;
        tick();
        req_valid[0] = 1'b0;
        n_vec++;
        if (req_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_fifth: ready=%b after fifth accept, required 0", req_ready[0]);
        end
        drain(0, 4, 20);
        n_vec++;
        if (got_inst.size() != 4) begin
            n_bad++;
            $display("FAIL bp_drain_count: got %0d, required 4", got_inst.size());
        end
        for (int i = 0; i < got_inst.size(); i++) begin
            n_vec++;
            if (got_inst[i] !== ref_mem[i+1] || got_err[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_drain[%0d]: inst=%h err=%b, required %h 0", i, got_inst[i], got_err[i], ref_mem[i+1]);
            end
        end
    endtask

    task automatic test_load_collision();
        rsp_ready[0] = 1'b1;
        ld_en        = 1'b1;
        ld_widx      = 8'd3;
        ld_data      = 32'hDEAD_BEEF;
        req_valid[0] = 1'b1;
        req_addr[0]  = BASE + 32'hC;
        tick();
        ld_en      = 1'b0;
        ref_mem[3] = 32'hDEAD_BEEF;
        tick();
        drain(0, 2, 20);
        n_vec++;
        if (got_inst.size() != 2) begin
            n_bad++;
            $display("FAIL ld_count: got %0d, required 2", got_inst.size());
        end else begin
            n_vec++;
            if (got_inst[0] !== 32'h0 || got_inst[1] !== 32'hDEAD_BEEF) begin
                n_bad++;
                $display("FAIL ld_collision: got %h then %h, required 00000000 then deadbeef", got_inst[0], got_inst[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        rsp_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[0] = 1'b1;
            req_addr[0]  = BASE + 32'(4 * i);
            tick();
        end
        req_valid[0] = 1'b0;
        n_vec++;
        if (rsp_valid[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre: valid=%b with 3 outstanding, required 1", rsp_valid[0]);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0 || rsp_inst[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid_async: valid=%b ready=%b inst=%h, required 0 0 0", rsp_valid[0], req_ready[0], rsp_inst[0]);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid[0]) stale++;
            tick();
        end
        n_vec++;
        if (stale != 0 || req_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_stale: stale=%0d ready=%b, required 0 1", stale, req_ready[0]);
        end
        req_valid[0] = 1'b1;
        req_addr[0]  = BASE;
        tick();
        drain(0, 1, 10);
        n_vec++;
        if (got_inst.size() != 1 || got_inst[0] !== 32'h2408_0005) begin
            n_bad++;
            $display("FAIL rst_mid_mem: got %0d rsp, first=%h, required 1 rsp 24080005",
                     got_inst.size(), (got_inst.size() > 0) ? got_inst[0] : 32'hX);
        end
    endtask

    task automatic test_random(input int d, input int n);
        exp_t        q [$];
        exp_t        e;
        int          accepts = 0;
        int          guard   = 0;
        logic        exp_v;
        logic        acc;
        logic        pop;
        logic [31:0] e_inst;
        logic        e_err;
        int          r;
        while ((accepts < n || q.size() > 0) && guard < 20000) begin
            guard++;
            exp_v = (q.size() > 0) && (q[0].acc_cyc + lat[d] <= cyc);
            n_vec++;
            if (rsp_valid[d] !== exp_v) begin
                n_bad++;
                $display("FAIL rand%0d_valid: cyc=%0d valid=%b, required %b", lat[d], cyc, rsp_valid[d], exp_v);
            end
            if (exp_v && rsp_valid[d]) begin
                n_vec++;
                if (rsp_inst[d] !== q[0].inst || rsp_err[d] !== q[0].err) begin
                    n_bad++;
                    $display("FAIL rand%0d_data: cyc=%0d inst=%h err=%b, required %h %b",
                             lat[d], cyc, rsp_inst[d], rsp_err[d], q[0].inst, q[0].err);
                end
            end
            n_vec++;
            if (req_ready[d] !== (q.size() < DEPTH)) begin
                n_bad++;
                $display("FAIL rand%0d_ready: cyc=%0d ready=%b outstanding=%0d", lat[d], cyc, req_ready[d], q.size());
            end
            rsp_ready[d] = ($urandom_range(0, 3) != 0);
            req_valid[d] = (accepts < n) && ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 9);
            if (r < 7)       req_addr[d] = BASE + 32'(4 * $urandom_range(0, 255));
            else if (r == 7) req_addr[d] = BASE + 32'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
            else if (r == 8) req_addr[d] = BASE - 32'(4 * $urandom_range(1, 3000));
            else             req_addr[d] = BASE + 32'd1024 + 32'(4 * $urandom_range(0, 100000));
            ld_en   = ($urandom_range(0, 15) == 0);
            ld_widx = 8'($urandom_range(0, 255));
            ld_data = $urandom;
            acc = req_valid[d] && req_ready[d];
            pop = rsp_valid[d] && rsp_ready[d];
            ref_rsp(req_addr[d], e_inst, e_err);
            tick();
            if (pop && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                e.inst    = e_inst;
                e.err     = e_err;
                e.acc_cyc = cyc;
                q.push_back(e);
                accepts++;
                n_vec++;
                if (q.size() > DEPTH) begin
                    n_bad++;
                    $display("FAIL rand%0d_cnt: outstanding=%0d, required <= %0d", lat[d], q.size(), DEPTH);
                end
            end
            if (ld_en) ref_mem[ld_widx] = ld_data;
            ld_en = 1'b0;
        end
        req_valid[d] = 1'b0;
        n_vec++;
        if (accepts != n || q.size() != 0) begin
            n_bad++;
            $display("FAIL rand%0d_timeout: accepts=%0d left=%0d, required %0d 0", lat[d], accepts, q.size(), n);
        end
    endtask

    initial begin
        test_reset();
        load_program();
        test_basic();
        test_errors();
        test_backpressure();
        test_load_collision();
        test_reset_mid();
        test_random(1, 1000);
        test_random(2, 1000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
